// File: rtl/alu_vec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_vec_pkg
//  Purpose  : Shared types and helpers for the sequential vector ALU.
//             - op_e    : 3-bit operation encoding driven on sel
//             - state_e : control FSM states
//             - calc_nchunk / calc_cnt_w : chunk count and counter width
//  Revision : 1.0 - initial release
// ============================================================================
package alu_vec_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SLL = 3'd6,
        OP_SRL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of processing passes needed to cover all lanes.
    function automatic int calc_nchunk(input int lanes, input int lanes_per_cycle);
        return lanes / lanes_per_cycle;
    endfunction

    // Chunk counter width; a single-chunk configuration still gets one bit.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage : alu_vec_pkg
`default_nettype wire

// File: rtl/alu_vec_seq_lane.sv
`default_nettype none
// ============================================================================
//  Module   : alu_lane
//  Purpose  : Combinational single-element unsigned ALU with optional
//             saturation and a per-element overflow indicator.
//  Ports    : a, b      - element operands (WIDTH)
//             op        - operation select (op_e)
//             saturate  - clamp add/sub/mul instead of wrapping
//             y         - element result (WIDTH)
//             ovf       - wrap/clamp indicator (independent of saturate)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_lane
    import alu_vec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic             saturate,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [SHW-1:0]     w_shamt;
    logic               w_mul_hi;

    // Widened arithmetic: the extra MSB of sum/diff is carry/borrow.
    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_diff   = {1'b0, a} - {1'b0, b};
    assign w_prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_mul_hi = |w_prod[2*WIDTH-1:WIDTH];
    assign w_shamt  = b[SHW-1:0];

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                ovf = w_sum[WIDTH];
                y   = (saturate && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                ovf = w_diff[WIDTH];
                y   = (saturate && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
            end
            OP_MUL: begin
                ovf = w_mul_hi;
                y   = (saturate && w_mul_hi) ? {WIDTH{1'b1}} : w_prod[WIDTH-1:0];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << w_shamt;
            OP_SRL:  y = a >> w_shamt;
            default: y = '0;
        endcase
    end

endmodule : alu_lane
`default_nettype wire

// File: rtl/alu_vec_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_vec_seq
//  Purpose  : Multi-cycle vector ALU. Accepts one operation per in_valid/
//             in_ready handshake, computes LANES_PER_CYCLE elements per cycle
//             and holds the result until out_valid/out_ready completes.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_ready       - request handshake (ready only in IDLE)
//             vectorA, vectorB, scalar - operands (scalar broadcast as B)
//             sel, operand_flag, saturate - operation controls
//             out_valid/out_ready     - result handshake
//             result, overflow        - element results, per-lane flags
//  Revision : 1.0 - initial release
// ============================================================================
module alu_vec_seq
    import alu_vec_pkg::*;
#(
    parameter int LANES           = 16,
    parameter int WIDTH           = 16,
    parameter int LANES_PER_CYCLE = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0][WIDTH-1:0]   vectorA,
    input  logic [LANES-1:0][WIDTH-1:0]   vectorB,
    input  logic [WIDTH-1:0]              scalar,
    input  logic [2:0]                    sel,
    input  logic                          operand_flag,
    input  logic                          saturate,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0][WIDTH-1:0]   result,
    output logic [LANES-1:0]              overflow
);

    localparam int NCHUNK = calc_nchunk(LANES, LANES_PER_CYCLE);
    localparam int CNT_W  = calc_cnt_w(NCHUNK);
    localparam int IDXW   = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [CNT_W-1:0] C_LAST_CHUNK = CNT_W'(NCHUNK - 1);

    if ((LANES % LANES_PER_CYCLE) != 0) begin : g_bad_params
        $fatal(1, "alu_vec_seq: LANES must be a multiple of LANES_PER_CYCLE");
    end

    state_e                        r_state;
    logic [CNT_W-1:0]              r_chunk;
    logic [LANES-1:0][WIDTH-1:0]   r_a;
    logic [LANES-1:0][WIDTH-1:0]   r_b;
    op_e                           r_op;
    logic                          r_sat;
    logic [LANES-1:0][WIDTH-1:0]   r_result;
    logic [LANES-1:0]              r_ovf;
    logic                          r_out_valid;

    logic [IDXW-1:0]               w_idx [LANES_PER_CYCLE];
    logic [WIDTH-1:0]              w_y   [LANES_PER_CYCLE];
    logic                          w_ovf [LANES_PER_CYCLE];

    // One lane unit per element processed each cycle; the current chunk
    // selects which slice of the registered operands feeds them.
    for (genvar k = 0; k < LANES_PER_CYCLE; k++) begin : g_lane
        assign w_idx[k] = IDXW'(int'(r_chunk) * LANES_PER_CYCLE + k);

        alu_lane #(
            .WIDTH    (WIDTH)
        ) u_lane (
            .a        (r_a[w_idx[k]]),
            .b        (r_b[w_idx[k]]),
            .op       (r_op),
            .saturate (r_sat),
            .y        (w_y[k]),
            .ovf      (w_ovf[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_chunk     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_ADD;
            r_sat       <= 1'b0;
            r_result    <= '0;
            r_ovf       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= vectorA;
                        r_b      <= operand_flag ? {LANES{scalar}} : vectorB;
                        r_op     <= op_e'(sel);
                        r_sat    <= saturate;
                        r_result <= '0;
                        r_ovf    <= '0;
                        r_chunk  <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < LANES_PER_CYCLE; k++) begin
                        r_result[w_idx[k]] <= w_y[k];
                        r_ovf[w_idx[k]]    <= w_ovf[k];
                    end
                    if (r_chunk == C_LAST_CHUNK) begin
                        r_chunk     <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_chunk <= r_chunk + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Result holds until the consumer takes it; no re-accept
                    // on the same edge.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_ovf;

endmodule : alu_vec_seq
`default_nettype wire
